// File: rtl/udp_rx_packer_if.sv
// udp_rx_packer_if: bundles the byte-stream input and the packed-packet output
// of udp_rx_packer.
//   udp_rec_data_valid / udp_rec_rdata : incoming UDP payload byte stream
//   rx_data / rx_data_length           : packed packet and its byte count
//   rx_data_valid / rx_data_ready      : output handshake
//   rx_truncated                       : presented packet overflowed capacity
//   rx_drop_cnt                        : saturating count of dropped packets
// master = stream source / packet consumer, slave = the packer.
interface udp_rx_packer_if #(
    parameter int MAX_BYTES = 120
);
    logic                   udp_rec_data_valid;
    logic [7:0]             udp_rec_rdata;
    logic [MAX_BYTES*8-1:0] rx_data;
    logic [15:0]            rx_data_length;
    logic                   rx_data_valid;
    logic                   rx_data_ready;
    logic                   rx_truncated;
    logic [7:0]             rx_drop_cnt;

    modport master (
        output udp_rec_data_valid, udp_rec_rdata, rx_data_ready,
        input  rx_data, rx_data_length, rx_data_valid, rx_truncated, rx_drop_cnt
    );

    modport slave (
        input  udp_rec_data_valid, udp_rec_rdata, rx_data_ready,
        output rx_data, rx_data_length, rx_data_valid, rx_truncated, rx_drop_cnt
    );
endinterface

// File: rtl/udp_rx_packer.sv
// udp_rx_packer: packs a contiguous burst of UDP payload bytes into one wide
// word (first byte in the MSBs) and presents it with a valid/ready handshake.
// Packets that arrive while the previous one is still presented are dropped
// whole and counted.
// Ports:
//   rgmii_clk : sole clock, rising edge
//   rst       : asynchronous, active-high reset
//   bus       : udp_rx_packer_if.slave (byte stream in, packed packet out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the first byte of a new packet
// RECV  | accumulating payload bytes into the packing register
// HOLD  | packet presented on rx_data, waiting for rx_data_ready
module udp_rx_packer #(
    parameter int MAX_BYTES = 120
) (
    input  logic           rgmii_clk,
    input  logic           rst,
    udp_rx_packer_if.slave bus
);
    localparam int          DW  = MAX_BYTES * 8;
    localparam logic [15:0] CAP = 16'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_data;
    logic [15:0]     r_count;
    logic [15:0]     r_len;
    logic            r_trunc_flag;
    logic            r_trunc;
    logic            r_drop_active;
    logic [7:0]      r_drop_cnt;

    logic            w_vld;
    logic            w_start;
    logic            w_recv_byte;
    logic            w_end;
    logic            w_drop_rise;

    assign w_vld       = bus.udp_rec_data_valid;
    // The tail of a dropped packet must never look like a new packet.
    assign w_start     = (r_state == IDLE) && w_vld && !r_drop_active;
    assign w_recv_byte = (r_state == RECV) && w_vld;
    assign w_end       = (r_state == RECV) && !w_vld;
    assign w_drop_rise = (r_state == HOLD) && w_vld && !r_drop_active;

    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start)           w_next = RECV;
            RECV:    if (!w_vld)            w_next = HOLD;
            HOLD:    if (bus.rx_data_ready) w_next = IDLE;
            default:                        w_next = IDLE;
        endcase
    end

    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst) begin
            r_data        <= '0;
            r_count       <= '0;
            r_len         <= '0;
            r_trunc_flag  <= 1'b0;
            r_trunc       <= 1'b0;
            r_drop_active <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_start) begin
                r_data       <= {bus.udp_rec_rdata, {(DW-8){1'b0}}};
                r_count      <= 16'd1;
                r_trunc_flag <= 1'b0;
            end else if (w_recv_byte) begin
                // Slot select by compare keeps every part-select constant.
                for (int i = 1; i < MAX_BYTES; i++) begin
                    if (r_count == 16'(i)) begin
                        r_data[DW-1-8*i -: 8] <= bus.udp_rec_rdata;
                    end
                end
                if (r_count >= CAP) begin
                    r_trunc_flag <= 1'b1;
                end
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end

            if (w_end) begin
                r_len   <= r_count;
                r_trunc <= r_trunc_flag;
            end

            // Any byte seen in HOLD marks the whole burst as dropped until
            // the stream goes idle.
            r_drop_active <= w_vld && (r_drop_active || (r_state == HOLD));

            if (w_drop_rise && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign bus.rx_data        = r_data;
    assign bus.rx_data_length = r_len;
    assign bus.rx_data_valid  = (r_state == HOLD);
    assign bus.rx_truncated   = r_trunc;
    assign bus.rx_drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_udp_rx_packer.sv
module tb_udp_rx_packer;
    localparam int MAXB = 120;
    localparam int DW   = MAXB * 8;
    localparam int HW   = DW / 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [15:0]   len;
        logic          trunc;
    } pkt_t;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_drop = 0;
    pkt_t sb[$];
    pkt_t exp_a;

    udp_rx_packer_if #(.MAX_BYTES(MAXB)) bus ();

    udp_rx_packer #(.MAX_BYTES(MAXB)) dut (
        .rgmii_clk (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        check({tag, "_hi"}, obs[DW-1:HW], exp[DW-1:HW]);
        check({tag, "_lo"}, obs[HW-1:0], exp[HW-1:0]);
    endtask

    function automatic pkt_t make_pkt(input int n, input logic [7:0] first, input logic [7:0] step);
        pkt_t p;
        p.data  = '0;
        for (int i = 0; i < n && i < MAXB; i++) begin
            p.data[DW-1-8*i -: 8] = 8'(first + 8'(i) * step);
        end
        p.len   = 16'(n);
        p.trunc = (n > MAXB);
        return p;
    endfunction

    // Drives one burst, then one idle cycle; optionally records the packet
    // the packer is expected to present.
    task automatic send_pkt(input int n, input logic [7:0] first, input logic [7:0] step, input bit push);
        if (push) sb.push_back(make_pkt(n, first, step));
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.udp_rec_data_valid = 1'b1;
            bus.udp_rec_rdata      = 8'(first + 8'(i) * step);
        end
        @(posedge clk); #1;
        bus.udp_rec_data_valid = 1'b0;
        bus.udp_rec_rdata      = 8'h00;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || bus.rx_data_valid) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain", HW'(sb.size()), '0);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.rx_data_valid && bus.rx_data_ready) begin
            check("sb_avail", HW'(sb.size() != 0), HW'(1));
            if (sb.size() != 0) begin
                pkt_t p;
                p = sb.pop_front();
                check_data("pkt_data", bus.rx_data, p.data);
                check("pkt_len", HW'(bus.rx_data_length), HW'(p.len));
                check("pkt_trunc", HW'(bus.rx_truncated), HW'(p.trunc));
            end
        end
    end

    initial begin
        pkt_t p;
        rst = 1'b1;
        bus.udp_rec_data_valid = 1'b0;
        bus.udp_rec_rdata      = 8'h00;
        bus.rx_data_ready      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", HW'(bus.rx_data_valid), '0);
        check("rst_len", HW'(bus.rx_data_length), '0);
        check("rst_trunc", HW'(bus.rx_truncated), '0);
        check("rst_drop", HW'(bus.rx_drop_cnt), '0);
        check_data("rst_data", bus.rx_data, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Four-byte packet, handshake timing.
        send_pkt(4, 8'h11, 8'h11, 1'b1);
        check("t1_vld_early", HW'(bus.rx_data_valid), '0);
        @(posedge clk); #1;
        check("t1_vld_rise", HW'(bus.rx_data_valid), HW'(1));
        @(posedge clk); #1;
        check("t1_vld_fall", HW'(bus.rx_data_valid), '0);
        p = make_pkt(4, 8'h11, 8'h11);
        check_data("t1_retain", bus.rx_data, p.data);
        check("t1_len_keep", HW'(bus.rx_data_length), HW'(4));
        drain();

        // Overflow: 130 bytes, only 120 kept.
        send_pkt(130, 8'h00, 8'h01, 1'b1);
        drain();

        // Exactly capacity.
        send_pkt(120, 8'h00, 8'h01, 1'b1);
        @(posedge clk); #1;
        check("t6_last_byte", HW'(bus.rx_data[7:0]), HW'(8'h77));
        check("t6_trunc", HW'(bus.rx_truncated), '0);
        drain();

        // Packet arriving while the previous one is held is dropped.
        bus.rx_data_ready = 1'b0;
        exp_a = make_pkt(5, 8'hA0, 8'h01);
        send_pkt(5, 8'hA0, 8'h01, 1'b1);
        send_pkt(10, 8'hB0, 8'h01, 1'b0);
        exp_drop = sat_inc(exp_drop);
        repeat (3) @(posedge clk);
        #1;
        check("t3_drop", HW'(bus.rx_drop_cnt), HW'(exp_drop));
        check("t3_vld", HW'(bus.rx_data_valid), HW'(1));
        check_data("t3_hold", bus.rx_data, exp_a.data);
        check("t3_len", HW'(bus.rx_data_length), HW'(5));
        bus.rx_data_ready = 1'b1;
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("t3_no_b", HW'(bus.rx_data_valid), '0);

        // Drop counter saturation.
        bus.rx_data_ready = 1'b0;
        exp_a = make_pkt(7, 8'hC3, 8'h05);
        send_pkt(7, 8'hC3, 8'h05, 1'b1);
        for (int k = 0; k < 300; k++) begin
            send_pkt(1, 8'(k), 8'h01, 1'b0);
            exp_drop = sat_inc(exp_drop);
            if (k == 2) check("t4_drop_mid", HW'(bus.rx_drop_cnt), HW'(exp_drop));
        end
        #1;
        check("t4_drop_sat", HW'(bus.rx_drop_cnt), HW'(exp_drop));
        check("t4_vld", HW'(bus.rx_data_valid), HW'(1));
        check_data("t4_hold", bus.rx_data, exp_a.data);
        bus.rx_data_ready = 1'b1;
        drain();

        // Reset mid-packet abandons it.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.udp_rec_data_valid = 1'b1;
            bus.udp_rec_rdata      = 8'(8'h50 + 8'(i));
        end
        #2;
        rst = 1'b1;
        #1;
        check("t5_vld", HW'(bus.rx_data_valid), '0);
        check("t5_len", HW'(bus.rx_data_length), '0);
        check("t5_trunc", HW'(bus.rx_truncated), '0);
        check("t5_drop", HW'(bus.rx_drop_cnt), '0);
        check_data("t5_data", bus.rx_data, '0);
        exp_drop = 0;
        bus.udp_rec_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_pkt(3, 8'h7E, 8'h01, 1'b1);
        @(posedge clk); #1;
        check("t5_new_len", HW'(bus.rx_data_length), HW'(3));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
